bcd_adder: RTL and testbench

- Registered, ripple-digit packed-BCD adder: adds two NDIGITS-digit BCD operands and produces a BCD sum plus a decimal carry-out.
- Sits in the datapath as a single-cycle-latency arithmetic stage with a simple valid qualifier.
- Flags operands that contain non-BCD nibbles (values 10-15); arithmetic on such nibbles is still fully defined.

---
 rtl/bcd_adder.sv | 70 +++++++
 tb/tb_bcd_adder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_adder.sv
// Registered ripple-digit packed-BCD adder with a non-BCD operand flag.
// One bcd_digit instance per digit; the decimal carry ripples from digit 0 upward.

module bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout,
    output logic       bad
);
    logic [4:0] s;

    always_comb begin
        s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        cout = (s >= 5'd10);
        // Adding 6 modulo 16 skips the six unused codes; invalid nibbles use the same rule.
        d    = cout ? (s[3:0] + 4'd6) : s[3:0];
        bad  = (a > 4'd9) || (b > 4'd9);
    end
endmodule

module bcd_adder #(
    parameter int NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [4*NDIGITS-1:0]   A,
    input  logic [4*NDIGITS-1:0]   B,
    output logic [4*NDIGITS-1:0]   Out,
    output logic                   Carry,
    output logic                   out_valid,
    output logic                   err
);
    logic [NDIGITS-1:0][3:0] a_dig, b_dig, sum_dig;
    logic [NDIGITS:0]        c;
    logic [NDIGITS-1:0]      bad;

    assign a_dig = A;
    assign b_dig = B;
    assign c[0]  = 1'b0;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
        bcd_digit u_dig (
            .a    (a_dig[i]),
            .b    (b_dig[i]),
            .cin  (c[i]),
            .d    (sum_dig[i]),
            .cout (c[i+1]),
            .bad  (bad[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out       <= '0;
            Carry     <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out   <= sum_dig;
                Carry <= c[NDIGITS];
                err   <= |bad;
            end
        end
    end
endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: directed corner cases plus randomized traffic
// against a digit-by-digit decimal reference model.

module tb_bcd_adder;
    localparam int N = 2;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Out;
    logic         Carry;
    logic         out_valid;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_out;
    logic         exp_carry;
    logic         exp_err;

    bcd_adder #(.NDIGITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Out       (Out),
        .Carry     (Carry),
        .out_valid (out_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: walk the decimal digits with integer arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] sum, output logic cy, output logic bad);
        int carry = 0;
        int s;
        int da, db;
        sum = '0;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            da = int'((a >> (4 * i)) & 'hF);
            db = int'((b >> (4 * i)) & 'hF);
            if (da > 9 || db > 9) bad = 1'b1;
            s = da + db + carry;
            if (s >= 10) begin
                s = (s + 6) % 16;
                carry = 1;
            end else begin
                carry = 0;
            end
            sum = sum | (W'(s) << (4 * i));
        end
        cy = (carry != 0);
    endtask

    task automatic check_outputs(input string tag, input logic want_valid);
        chk({tag, ".out"},   32'(Out),       32'(exp_out));
        chk({tag, ".carry"}, 32'(Carry),     32'(exp_carry));
        chk({tag, ".err"},   32'(err),       32'(exp_err));
        chk({tag, ".valid"}, 32'(out_valid), 32'(want_valid));
    endtask

    // Presents one operation at the falling edge and checks it after the next rising edge.
    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        model(a, b, exp_out, exp_carry, exp_err);
        @(posedge clk);
        #1;
        check_outputs(tag, 1'b1);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        @(posedge clk);
        #1;
        check_outputs(tag, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v = '0;
        for (int i = 0; i < N; i++)
            v = v | (W'($urandom_range(9)) << (4 * i));
        return v;
    endfunction

    initial begin
        exp_out = '0;
        exp_carry = 1'b0;
        exp_err = 1'b0;
        #12;
        check_outputs("reset", 1'b0);
        rst_n = 1'b1;

        op("x62_59", 8'h62, 8'h59);
        chk("x62_59.lit", 32'(Out), 32'h21);
        op("x43_B5", 8'h43, 8'hB5);
        chk("x43_B5.lit", 32'(Out), 32'h58);
        op("x29_6C", 8'h29, 8'h6C);
        chk("x29_6C.lit", 32'(Out), 32'h9B);
        op("x99_99", 8'h99, 8'h99);
        chk("x99_99.lit", 32'({Carry, Out}), 32'h198);
        op("x50_50", 8'h50, 8'h50);
        op("x00_00", 8'h00, 8'h00);

        // back-to-back then hold
        op("b2b0", 8'h15, 8'h27);
        op("b2b1", 8'h88, 8'h19);
        op("b2b2", 8'h99, 8'h01);
        idle("hold0");
        idle("hold1");

        // asynchronous reset mid-cycle with nonzero outputs
        op("pre_rst", 8'h99, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        exp_out = '0;
        exp_carry = 1'b0;
        exp_err = 1'b0;
        check_outputs("async_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] a, b;
            if ($urandom_range(3) != 0) begin
                a = rand_bcd();
                b = rand_bcd();
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if ($urandom_range(4) != 0) op("rand", a, b);
            else idle("rand_idle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
